// File: rtl/serial_fulladder_driver.sv
// Bit-serial sequencer for a single-bit full-adder stage: feeds operand bits LSB first,
// waits SETTLE_CYCLES per bit, and collects sum/carry into a WIDTH-bit result.
module serial_fulladder_driver #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             fa_x,
  output logic             fa_y,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [IDX_W-1:0] bit_idx;
  logic [CNT_W-1:0] settle_cnt;

  logic [WIDTH-1:0] a_nx;
  logic [WIDTH-1:0] b_nx;
  logic [WIDTH-1:0] sum_nx;

  // Next-bit values after a sample edge; written without slices so WIDTH=1 stays legal.
  always_comb begin
    a_nx              = a_sh >> 1;
    b_nx              = b_sh >> 1;
    sum_nx            = sum_sh >> 1;
    sum_nx[WIDTH-1]   = fa_sum;
  end

  // fa_* are loaded one step ahead so they always equal a_sh[0]/b_sh[0]/carry while in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      sum_sh     <= '0;
      carry      <= 1'b0;
      bit_idx    <= '0;
      settle_cnt <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_cout   <= 1'b0;
      fa_x       <= 1'b0;
      fa_y       <= 1'b0;
      fa_cin     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh       <= in_a;
            b_sh       <= in_b;
            carry      <= in_cin;
            bit_idx    <= '0;
            settle_cnt <= SETTLE_INIT;
            fa_x       <= in_a[0];
            fa_y       <= in_b[0];
            fa_cin     <= in_cin;
            in_ready   <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end else begin
            sum_sh     <= sum_nx;
            carry      <= fa_cout;
            a_sh       <= a_nx;
            b_sh       <= b_nx;
            bit_idx    <= bit_idx + IDX_W'(1);
            settle_cnt <= SETTLE_INIT;
            if (bit_idx == LAST_IDX) begin
              fa_x      <= 1'b0;
              fa_y      <= 1'b0;
              fa_cin    <= 1'b0;
              out_valid <= 1'b1;
              out_sum   <= sum_nx;
              out_cout  <= fa_cout;
              state     <= DONE;
            end else begin
              fa_x   <= a_nx[0];
              fa_y   <= b_nx[0];
              fa_cin <= fa_cout;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
